timer_countdown: RTL and testbench

//  MM:SS BCD countdown timer. Consumes the per-digit Preset/Clear nibbles driven by the

---
 rtl/timer_countdown.sv | 142 ++++++++++++++
 tb/tb_timer_countdown.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_countdown.sv
// MM:SS BCD countdown timer with per-bit preset/clear load,
// pause/resume and a one-cycle done pulse at 00:00.
module timer_countdown #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic [3:0] preset_us,
  input  logic [3:0] preset_ds,
  input  logic [3:0] preset_um,
  input  logic [3:0] preset_dm,
  input  logic [3:0] clear_us,
  input  logic [3:0] clear_ds,
  input  logic [3:0] clear_um,
  input  logic [3:0] clear_dm,
  output logic [3:0] us,
  output logic [3:0] ds,
  output logic [3:0] um,
  output logic [3:0] dm,
  output logic       running,
  output logic       done
);

  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  state_t     state, state_n;
  logic [W-1:0] pre, pre_n;
  logic [3:0] us_n, ds_n, um_n, dm_n;
  logic       done_n;
  logic       zero;
  logic       last_sec;

  // clear dominates preset; untouched bits keep their value
  function automatic logic [3:0] ld(
    input logic [3:0] cur,
    input logic [3:0] p,
    input logic [3:0] c,
    input logic [3:0] mx
  );
    logic [3:0] v;
    v = (p & ~c) | (cur & ~p & ~c);
    return (v > mx) ? mx : v;
  endfunction

  assign zero     = (dm == 4'd0) && (um == 4'd0) &&
                    (ds == 4'd0) && (us == 4'd0);
  assign last_sec = (dm == 4'd0) && (um == 4'd0) &&
                    (ds == 4'd0) && (us == 4'd1);

  always_comb begin
    state_n = state;
    pre_n   = pre;
    us_n    = us;
    ds_n    = ds;
    um_n    = um;
    dm_n    = dm;
    done_n  = 1'b0;
    if (load) begin
      us_n    = ld(us, preset_us, clear_us, 4'd9);
      ds_n    = ld(ds, preset_ds, clear_ds, 4'd5);
      um_n    = ld(um, preset_um, clear_um, 4'd9);
      dm_n    = ld(dm, preset_dm, clear_dm, 4'd9);
      state_n = IDLE;
      pre_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && !zero) begin
            state_n = RUN;
            pre_n   = '0;
          end
        end
        RUN: begin
          if (pause) begin
            state_n = PAUSED;
          end else if (pre == LAST) begin
            pre_n = '0;
            // RUN never holds 00:00, so dm cannot underflow here
            if (us != 4'd0) begin
              us_n = us - 4'd1;
            end else begin
              us_n = 4'd9;
              if (ds != 4'd0) begin
                ds_n = ds - 4'd1;
              end else begin
                ds_n = 4'd5;
                if (um != 4'd0) begin
                  um_n = um - 4'd1;
                end else begin
                  um_n = 4'd9;
                  dm_n = dm - 4'd1;
                end
              end
            end
            if (last_sec) begin
              state_n = DONE;
              done_n  = 1'b1;
            end
          end else begin
            pre_n = pre + W'(1);
          end
        end
        PAUSED: begin
          if (start && !pause) state_n = RUN;
        end
        DONE: begin
          state_n = DONE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pre     <= '0;
      us      <= 4'd0;
      ds      <= 4'd0;
      um      <= 4'd0;
      dm      <= 4'd0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      pre     <= pre_n;
      us      <= us_n;
      ds      <= ds_n;
      um      <= um_n;
      dm      <= dm_n;
      running <= (state_n == RUN);
      done    <= done_n;
    end
  end

endmodule

// File: tb/tb_timer_countdown.sv
// Bench for timer_countdown: directed scenarios plus random
// stimulus against a seconds-based reference model.
module tb_timer_countdown;

  localparam int TD = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic load = 1'b0;
  logic start = 1'b0;
  logic pause = 1'b0;
  logic [3:0] preset_us = '0, preset_ds = '0;
  logic [3:0] preset_um = '0, preset_dm = '0;
  logic [3:0] clear_us = '0, clear_ds = '0;
  logic [3:0] clear_um = '0, clear_dm = '0;
  logic [3:0] us, ds, um, dm;
  logic running, done;
  logic [15:0] obs;

  int checks = 0;
  int errors = 0;

  // model: time held as plain seconds
  int m_secs = 0;
  int m_st = 0;  // 0 idle, 1 run, 2 paused, 3 done
  int m_pre = 0;
  bit m_done = 1'b0;
  bit m_run = 1'b0;

  timer_countdown #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .load(load),
    .start(start), .pause(pause),
    .preset_us(preset_us), .preset_ds(preset_ds),
    .preset_um(preset_um), .preset_dm(preset_dm),
    .clear_us(clear_us), .clear_ds(clear_ds),
    .clear_um(clear_um), .clear_dm(clear_dm),
    .us(us), .ds(ds), .um(um), .dm(dm),
    .running(running), .done(done)
  );

  assign obs = {dm, um, ds, us};

  always #5 clk = ~clk;

  function automatic logic [15:0] m_dig(input int s);
    logic [15:0] r;
    r[15:12] = 4'(s / 600);
    r[11:8]  = 4'((s / 60) % 10);
    r[7:4]   = 4'((s % 60) / 10);
    r[3:0]   = 4'(s % 10);
    return r;
  endfunction

  function automatic int m_ld(input logic [3:0] cur, input logic [3:0] p,
                              input logic [3:0] c, input int mx);
    logic [3:0] v;
    for (int b = 0; b < 4; b++) begin
      if (c[b]) v[b] = 1'b0;
      else if (p[b]) v[b] = 1'b1;
      else v[b] = cur[b];
    end
    return (int'(v) > mx) ? mx : int'(v);
  endfunction

  task automatic m_step();
    logic [15:0] d;
    if (reset) begin
      m_secs = 0; m_st = 0; m_pre = 0; m_done = 0;
    end else if (load) begin
      d = m_dig(m_secs);
      m_secs = m_ld(d[15:12], preset_dm, clear_dm, 9) * 600
             + m_ld(d[11:8], preset_um, clear_um, 9) * 60
             + m_ld(d[7:4], preset_ds, clear_ds, 5) * 10
             + m_ld(d[3:0], preset_us, clear_us, 9);
      m_st = 0; m_pre = 0; m_done = 0;
    end else begin
      m_done = 0;
      case (m_st)
        0: if (start && m_secs != 0) begin m_st = 1; m_pre = 0; end
        1: begin
          if (pause) m_st = 2;
          else if (m_pre == TD - 1) begin
            m_pre = 0;
            m_secs = m_secs - 1;
            if (m_secs == 0) begin m_st = 3; m_done = 1; end
          end else m_pre = m_pre + 1;
        end
        2: if (start && !pause) m_st = 1;
        default: ;
      endcase
    end
    m_run = (m_st == 1);
  endtask

  task automatic cyc();
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic set_val(input int a, input int b, input int c, input int e);
    preset_dm = 4'(a); preset_um = 4'(b);
    preset_ds = 4'(c); preset_us = 4'(e);
    clear_dm = ~preset_dm; clear_um = ~preset_um;
    clear_ds = ~preset_ds; clear_us = ~preset_us;
    load = 1'b1;
    cyc();
    load = 1'b0;
    {preset_dm, preset_um, preset_ds, preset_us} = '0;
    {clear_dm, clear_um, clear_ds, clear_us} = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    checks++;
    if (obs !== 16'h0000 || running !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_init got=%h run=%b done=%b exp=0000 0 0", obs, running, done);
    end
    set_val(0, 1, 3, 0);
    start = 1'b1;
    repeat (6) cyc();
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    checks++;
    if (obs !== 16'h0000 || running !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_run got=%h run=%b done=%b exp=0000 0 0", obs, running, done);
    end
    repeat (3) begin
      cyc();
      checks++;
      if (obs !== 16'h0000 || running !== 1'b0) begin
        errors++;
        $display("FAIL reset_start got=%h run=%b exp=0000 0", obs, running);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_countdown();
    set_val(0, 1, 3, 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 1; i <= 128; i++) begin
      cyc();
      checks++;
      if (obs !== m_dig(m_secs) || running !== m_run) begin
        errors++;
        $display("FAIL count_trace i=%0d got=%h/%b exp=%h/%b", i, obs, running, m_dig(m_secs), m_run);
      end
      if (i == 4 || i == 120 || i == 124) begin
        checks++;
        if (obs !== (i == 4 ? 16'h0129 : i == 120 ? 16'h0100 : 16'h0059)) begin
          errors++;
          $display("FAIL count_point i=%0d got=%h", i, obs);
        end
      end
    end
  endtask

  task automatic test_done();
    set_val(0, 0, 0, 2);
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      cyc();
      checks++;
      if (obs !== m_dig(m_secs) || done !== m_done || running !== m_run) begin
        errors++;
        $display("FAIL done_trace i=%0d got=%h/%b/%b exp=%h/%b/%b", i, obs, done, running, m_dig(m_secs), m_done, m_run);
      end
      if (i == 4) begin
        checks++;
        if (obs !== 16'h0001 || done !== 1'b0) begin
          errors++;
          $display("FAIL done_mid got=%h/%b exp=0001/0", obs, done);
        end
      end
      if (i == 8) begin
        checks++;
        if (obs !== 16'h0000 || done !== 1'b1 || running !== 1'b0) begin
          errors++;
          $display("FAIL done_pulse got=%h/%b/%b exp=0000/1/0", obs, done, running);
        end
      end
      if (i == 9) begin
        checks++;
        if (done !== 1'b0) begin
          errors++;
          $display("FAIL done_width got=%b exp=0", done);
        end
      end
    end
    for (int i = 0; i < 6; i++) begin
      start = i[0];
      cyc();
      checks++;
      if (obs !== 16'h0000 || done !== 1'b0 || running !== 1'b0) begin
        errors++;
        $display("FAIL done_hold got=%h/%b/%b exp=0000/0/0", obs, done, running);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_pause();
    set_val(0, 0, 1, 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc();
    pause = 1'b1;
    cyc();
    repeat (20) begin
      start = 1'($urandom_range(1));
      cyc();
      checks++;
      if (obs !== 16'h0010 || running !== 1'b0) begin
        errors++;
        $display("FAIL pause_hold got=%h/%b exp=0010/0", obs, running);
      end
    end
    pause = 1'b0;
    start = 1'b1;
    cyc();
    checks++;
    if (running !== 1'b1 || obs !== 16'h0010) begin
      errors++;
      $display("FAIL pause_resume got=%h/%b exp=0010/1", obs, running);
    end
    cyc();
    checks++;
    if (obs !== 16'h0010) begin
      errors++;
      $display("FAIL pause_early got=%h exp=0010", obs);
    end
    cyc();
    checks++;
    if (obs !== 16'h0009 || obs !== m_dig(m_secs)) begin
      errors++;
      $display("FAIL pause_tick got=%h exp=0009 model=%h", obs, m_dig(m_secs));
    end
    start = 1'b0;
  endtask

  task automatic test_load_rules();
    set_val(1, 2, 3, 4);
    preset_us = 4'hC;
    load = 1'b1; cyc(); load = 1'b0;
    preset_us = 4'h0;
    checks++;
    if (obs !== 16'h1239 || obs !== m_dig(m_secs)) begin
      errors++;
      $display("FAIL load_us_clamp got=%h exp=1239", obs);
    end
    preset_ds = 4'h7;
    load = 1'b1; cyc(); load = 1'b0;
    preset_ds = 4'h0;
    checks++;
    if (obs !== 16'h1259 || obs !== m_dig(m_secs)) begin
      errors++;
      $display("FAIL load_ds_clamp got=%h exp=1259", obs);
    end
    preset_dm = 4'hF; clear_dm = 4'hF;
    load = 1'b1; cyc(); load = 1'b0;
    preset_dm = 4'h0; clear_dm = 4'h0;
    checks++;
    if (obs !== 16'h0259 || obs !== m_dig(m_secs)) begin
      errors++;
      $display("FAIL load_clear got=%h exp=0259", obs);
    end
    load = 1'b1; cyc(); load = 1'b0;
    checks++;
    if (obs !== 16'h0259) begin
      errors++;
      $display("FAIL load_keep got=%h exp=0259", obs);
    end
    start = 1'b1;
    cyc(); cyc();
    preset_us = 4'd5; clear_us = 4'hA;
    clear_ds = 4'hF; clear_um = 4'hF; clear_dm = 4'hF;
    load = 1'b1;
    cyc();
    load = 1'b0;
    checks++;
    if (obs !== 16'h0005 || running !== 1'b0) begin
      errors++;
      $display("FAIL load_over_start got=%h/%b exp=0005/0", obs, running);
    end
    start = 1'b0;
    {preset_dm, preset_um, preset_ds, preset_us} = '0;
    {clear_dm, clear_um, clear_ds, clear_us} = '0;
  endtask

  task automatic test_borrow();
    set_val(1, 0, 0, 0);
    start = 1'b1; cyc(); start = 1'b0;
    repeat (4) cyc();
    checks++;
    if (obs !== 16'h0959) begin
      errors++;
      $display("FAIL borrow_1000 got=%h exp=0959", obs);
    end
    set_val(9, 9, 5, 9);
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 1; i <= 800; i++) begin
      cyc();
      checks++;
      if (obs !== m_dig(m_secs) || running !== 1'b1) begin
        errors++;
        $display("FAIL borrow_trace i=%0d got=%h/%b exp=%h/1", i, obs, running, m_dig(m_secs));
      end
      if (i == 4) begin
        checks++;
        if (obs !== 16'h9958) begin
          errors++;
          $display("FAIL borrow_max got=%h exp=9958", obs);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      reset = ($urandom_range(127) == 0);
      load  = ($urandom_range(15) == 0);
      start = 1'($urandom_range(1));
      pause = ($urandom_range(3) == 0);
      preset_us = 4'($urandom); preset_ds = 4'($urandom);
      preset_um = 4'($urandom); preset_dm = 4'($urandom);
      clear_us = 4'($urandom); clear_ds = 4'($urandom) | 4'hE;
      clear_um = 4'($urandom) | 4'hE; clear_dm = 4'($urandom) | 4'hE;
      cyc();
      checks++;
      if (obs !== m_dig(m_secs) || running !== m_run || done !== m_done) begin
        errors++;
        $display("FAIL random i=%0d got=%h/%b/%b exp=%h/%b/%b", i, obs, running, done, m_dig(m_secs), m_run, m_done);
      end
    end
    {reset, load, start, pause} = '0;
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_done();
    test_pause();
    test_load_rules();
    test_borrow();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
